// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Free-running horizontal/vertical counters advance on each pix_en pulse.
// Sync, active, coordinates and strobes are all registered from the
// next-state counter values, so they line up exactly with hc/vc.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start
);

    // Segment order on each axis: sync, back porch, active, front porch.
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START   = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_START   = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_END     = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_END     = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic             HS_ON     = (HS_POL != 0);
    localparam logic             VS_ON     = (VS_POL != 0);

    logic [CNT_W-1:0] hc_nxt;
    logic [CNT_W-1:0] vc_nxt;
    logic             h_act_nxt;
    logic             v_act_nxt;
    logic             act_nxt;

    // Next raster position: wrap hc at end of line, step vc on each wrap.
    always_comb begin
        hc_nxt = hc + 1'b1;
        vc_nxt = vc;
        if (hc == H_LAST) begin
            hc_nxt = '0;
            vc_nxt = (vc == V_LAST) ? '0 : vc + 1'b1;
        end
    end

    assign h_act_nxt = (hc_nxt >= H_START) && (hc_nxt < H_END);
    assign v_act_nxt = (vc_nxt >= V_START) && (vc_nxt < V_END);
    assign act_nxt   = h_act_nxt && v_act_nxt;

    // Counters, level outputs and strobes, all decoded from the next position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc           <= '0;
            vc           <= '0;
            hsync        <= HS_ON;
            vsync        <= VS_ON;
            active       <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (pix_en) begin
                hc           <= hc_nxt;
                vc           <= vc_nxt;
                hsync        <= (hc_nxt < H_SYNC_E) ? HS_ON : ~HS_ON;
                vsync        <= (vc_nxt < V_SYNC_E) ? VS_ON : ~VS_ON;
                active       <= act_nxt;
                x            <= act_nxt ? (hc_nxt - H_START) : '0;
                y            <= act_nxt ? (vc_nxt - V_START) : '0;
                line_start   <= (hc_nxt == '0);
                frame_start  <= (hc_nxt == '0) && (vc_nxt == '0);
                vblank_start <= (hc_nxt == '0) && (vc_nxt == V_END);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default 640x480 timing, a tiny raster for
// whole-frame and wrap behaviour, and an 800x600 positive-sync variant.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pen_d = 1'b0;
    logic pen_s = 1'b0;
    logic pen_w = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance
    logic d_hs, d_vs, d_act, d_ls, d_fs, d_vb;
    logic [9:0] d_x, d_y, d_hc, d_vc;
    vga_timing_gen u_d (
        .clk(clk), .rst(rst), .pix_en(pen_d),
        .hsync(d_hs), .vsync(d_vs), .active(d_act), .x(d_x), .y(d_y),
        .hc(d_hc), .vc(d_vc), .line_start(d_ls), .frame_start(d_fs),
        .vblank_start(d_vb)
    );

    // Tiny instance: H_TOTAL=15 (active hc 5..12), V_TOTAL=10 (active vc 4..8)
    logic s_hs, s_vs, s_act, s_ls, s_fs, s_vb;
    logic [5:0] s_x, s_y, s_hc, s_vc;
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .CNT_W(6)
    ) u_s (
        .clk(clk), .rst(rst), .pix_en(pen_s),
        .hsync(s_hs), .vsync(s_vs), .active(s_act), .x(s_x), .y(s_y),
        .hc(s_hc), .vc(s_vc), .line_start(s_ls), .frame_start(s_fs),
        .vblank_start(s_vb)
    );

    // 800x600 variant with positive syncs: H_TOTAL=1056, V_TOTAL=628
    logic w_hs, w_vs, w_act, w_ls, w_fs, w_vb;
    logic [10:0] w_x, w_y, w_hc, w_vc;
    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1), .VS_POL(1), .CNT_W(11)
    ) u_w (
        .clk(clk), .rst(rst), .pix_en(pen_w),
        .hsync(w_hs), .vsync(w_vs), .active(w_act), .x(w_x), .y(w_y),
        .hc(w_hc), .vc(w_vc), .line_start(w_ls), .frame_start(w_fs),
        .vblank_start(w_vb)
    );

    typedef struct {
        int   steps;
        int   hc;
        int   vc;
        logic hs;
        logic vs;
        logic act;
        int   x;
        int   y;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    // Hold pix_en high for n consecutive clocks on the selected instance.
    task automatic run(input int which, input int n);
        if (n > 0) begin
            @(negedge clk);
            case (which)
                0: pen_d = 1'b1;
                1: pen_s = 1'b1;
                default: pen_w = 1'b1;
            endcase
            repeat (n) @(negedge clk);
            pen_d = 1'b0;
            pen_s = 1'b0;
            pen_w = 1'b0;
        end
    endtask

    // One single-clock pix_en pulse on the tiny instance; returns at the
    // negedge right after the update edge.
    task automatic pulse_s();
        @(negedge clk);
        pen_s = 1'b1;
        @(negedge clk);
        pen_s = 1'b0;
    endtask

    int n_ls, n_fs, n_vb, n_hs, n_vs, n_act, n_extra;
    int fs_idx[2];
    int ls_first, ls_last;
    int hold_hc;

    initial begin
        // hc, vc, hs, vs, act, x, y after 'steps' further pix_en clocks
        tbl[0]  = '{0,     0,   0,  1'b0, 1'b0, 1'b0, 0,   0};
        tbl[1]  = '{95,    95,  0,  1'b0, 1'b0, 1'b0, 0,   0};
        tbl[2]  = '{1,     96,  0,  1'b1, 1'b0, 1'b0, 0,   0};
        tbl[3]  = '{48,    144, 0,  1'b1, 1'b0, 1'b0, 0,   0};
        tbl[4]  = '{656,   0,   1,  1'b0, 1'b0, 1'b0, 0,   0};
        tbl[5]  = '{800,   0,   2,  1'b0, 1'b1, 1'b0, 0,   0};
        tbl[6]  = '{799,   799, 2,  1'b1, 1'b1, 1'b0, 0,   0};
        tbl[7]  = '{22545, 144, 31, 1'b1, 1'b1, 1'b1, 0,   0};
        tbl[8]  = '{1,     145, 31, 1'b1, 1'b1, 1'b1, 1,   0};
        tbl[9]  = '{638,   783, 31, 1'b1, 1'b1, 1'b1, 639, 0};
        tbl[10] = '{1,     784, 31, 1'b1, 1'b1, 1'b0, 0,   0};
        tbl[11] = '{160,   144, 32, 1'b1, 1'b1, 1'b1, 0,   1};

        // Reset values while rst is held
        repeat (3) @(negedge clk);
        chk("rst_d_hsync", int'(d_hs), 0);
        chk("rst_w_hsync", int'(w_hs), 1);
        chk("rst_w_vsync", int'(w_vs), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_d_ls", int'(d_ls), 0);
        chk("idle_d_fs", int'(d_fs), 0);
        chk("idle_d_vb", int'(d_vb), 0);

        // Default timing table
        for (int i = 0; i < 12; i++) begin
            run(0, tbl[i].steps);
            chk($sformatf("d%0d_hc", i), int'(d_hc), tbl[i].hc);
            chk($sformatf("d%0d_vc", i), int'(d_vc), tbl[i].vc);
            chk($sformatf("d%0d_hs", i), int'(d_hs), int'(tbl[i].hs));
            chk($sformatf("d%0d_vs", i), int'(d_vs), int'(tbl[i].vs));
            chk($sformatf("d%0d_act", i), int'(d_act), int'(tbl[i].act));
            chk($sformatf("d%0d_x", i), int'(d_x), tbl[i].x);
            chk($sformatf("d%0d_y", i), int'(d_y), tbl[i].y);
            hold_hc = tbl[i].hc;
            repeat (2) @(negedge clk);
            chk($sformatf("d%0d_hold_hc", i), int'(d_hc), hold_hc);
            chk($sformatf("d%0d_hold_ls", i), int'(d_ls), 0);
        end

        // Asynchronous reset mid-frame
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_hc", int'(d_hc), 0);
        chk("mrst_vc", int'(d_vc), 0);
        chk("mrst_act", int'(d_act), 0);
        chk("mrst_x", int'(d_x), 0);
        chk("mrst_y", int'(d_y), 0);
        chk("mrst_hs", int'(d_hs), 0);
        chk("mrst_vs", int'(d_vs), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_ls", int'(d_ls), 0);
        chk("mrst_fs", int'(d_fs), 0);
        chk("mrst_hold_hc", int'(d_hc), 0);

        // Tiny raster: two frames with pix_en every 4th clk
        n_ls = 0; n_fs = 0; n_vb = 0; n_hs = 0; n_vs = 0; n_act = 0; n_extra = 0;
        fs_idx[0] = -1; fs_idx[1] = -1; ls_first = -1; ls_last = -1;
        for (int p = 1; p <= 300; p++) begin
            pulse_s();
            if (s_ls) begin
                n_ls++;
                if (ls_first < 0) ls_first = p;
                ls_last = p;
            end
            if (s_fs) begin
                if (n_fs < 2) fs_idx[n_fs] = p;
                n_fs++;
            end
            if (s_vb) n_vb++;
            if (!s_hs) n_hs++;
            if (!s_vs) n_vs++;
            if (s_act) n_act++;
            repeat (2) begin
                @(negedge clk);
                if (s_ls || s_fs || s_vb) n_extra++;
            end
        end
        chk("s_line_starts", n_ls, 20);
        chk("s_line_first", ls_first, 15);
        chk("s_line_last", ls_last, 300);
        chk("s_frame_starts", n_fs, 2);
        chk("s_frame_first", fs_idx[0], 150);
        chk("s_frame_period", fs_idx[1] - fs_idx[0], 150);
        chk("s_vblank_starts", n_vb, 2);
        chk("s_hsync_low", n_hs, 60);
        chk("s_vsync_low", n_vs, 60);
        chk("s_active", n_act, 80);
        chk("s_strobe_width", n_extra, 0);

        // Tiny raster corner positions, starting at (0,0)
        run(1, 65);
        chk("s_start_hc", int'(s_hc), 5);
        chk("s_start_vc", int'(s_vc), 4);
        chk("s_start_act", int'(s_act), 1);
        chk("s_start_x", int'(s_x), 0);
        chk("s_start_y", int'(s_y), 0);
        run(1, 67);
        chk("s_max_act", int'(s_act), 1);
        chk("s_max_x", int'(s_x), 7);
        chk("s_max_y", int'(s_y), 4);
        pulse_s();
        chk("s_fp_hc", int'(s_hc), 13);
        chk("s_fp_act", int'(s_act), 0);
        chk("s_fp_x", int'(s_x), 0);
        pulse_s();
        pulse_s();
        chk("s_vb_hc", int'(s_hc), 0);
        chk("s_vb_vc", int'(s_vc), 9);
        chk("s_vb_pulse", int'(s_vb), 1);
        chk("s_vb_ls", int'(s_ls), 1);
        chk("s_vb_fs", int'(s_fs), 0);
        @(negedge clk);
        chk("s_vb_drop", int'(s_vb), 0);
        run(1, 14);
        chk("s_end_hc", int'(s_hc), 14);
        chk("s_end_vc", int'(s_vc), 9);
        pulse_s();
        chk("s_wrap_hc", int'(s_hc), 0);
        chk("s_wrap_vc", int'(s_vc), 0);
        chk("s_wrap_ls", int'(s_ls), 1);
        chk("s_wrap_fs", int'(s_fs), 1);
        chk("s_wrap_vb", int'(s_vb), 0);
        chk("s_wrap_hs", int'(s_hs), 0);
        chk("s_wrap_vs", int'(s_vs), 0);
        @(negedge clk);
        chk("s_wrap_ls_drop", int'(s_ls), 0);
        chk("s_wrap_fs_drop", int'(s_fs), 0);

        // 800x600 positive-sync variant
        chk("w_rst_hs", int'(w_hs), 1);
        chk("w_rst_vs", int'(w_vs), 1);
        run(2, 127);
        chk("w_127_hs", int'(w_hs), 1);
        run(2, 1);
        chk("w_128_hc", int'(w_hc), 128);
        chk("w_128_hs", int'(w_hs), 0);
        run(2, 88);
        chk("w_216_0_act", int'(w_act), 0);
        run(2, 27456);
        chk("w_216_26_vc", int'(w_vc), 26);
        chk("w_216_26_act", int'(w_act), 0);
        run(2, 1055);
        chk("w_215_27_hc", int'(w_hc), 215);
        chk("w_215_27_act", int'(w_act), 0);
        chk("w_215_27_vs", int'(w_vs), 0);
        run(2, 1);
        chk("w_216_27_hc", int'(w_hc), 216);
        chk("w_216_27_vc", int'(w_vc), 27);
        chk("w_216_27_act", int'(w_act), 1);
        chk("w_216_27_x", int'(w_x), 0);
        chk("w_216_27_y", int'(w_y), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
